mem_stage: RTL and testbench

- Memory stage directly downstream of the execute stage.
- Registers the ALU result and control bits coming out of execute.
- Performs loads and stores over a request/acknowledge data-memory port, with byte/half/word lane alignment and sign/zero extension.
- Presents a single-cycle-valid writeback bundle to the writeback stage, and holds execute via `stall` while a memory access is outstanding.

---
 rtl/mem_stage_pkg.sv | 55 +++++
 rtl/mem_stage_if.sv | 45 ++++
 rtl/mem_stage_load_align.sv | 31 +++
 rtl/mem_stage.sv | 165 ++++++++++++++++
 tb/tb_mem_stage.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory stage and its neighbours.
package mem_stage_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned STRB_WIDTH     = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  typedef struct packed {
    logic                      valid;
    logic                      reg_write;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     data;
    logic [ADDR_WIDTH-1:0]     pc;
  } wb_t;

  // Reserved size behaves as a word access.
  function automatic logic is_misaligned(mem_size_e size, logic [1:0] off);
    case (size)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return off[0];
      default:  return off != 2'b00;
    endcase
  endfunction

  function automatic logic [STRB_WIDTH-1:0] store_strb(mem_size_e size, logic [1:0] off);
    case (size)
      MEM_BYTE: return 4'b0001 << off;
      MEM_HALF: return 4'b0011 << {off[1], 1'b0};
      default:  return 4'b1111;
    endcase
  endfunction

  // Replicate the store lane so any byte enable pattern picks the right bytes.
  function automatic logic [DATA_WIDTH-1:0] store_wdata(mem_size_e size, logic [DATA_WIDTH-1:0] d);
    case (size)
      MEM_BYTE: return {4{d[7:0]}};
      MEM_HALF: return {2{d[15:0]}};
      default:  return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Execute-side, data-memory and writeback signals of the memory stage.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic                      flush;
  logic                      ex_valid;
  logic [ADDR_WIDTH-1:0]     pc;
  logic [DATA_WIDTH-1:0]     alu_out;
  logic [DATA_WIDTH-1:0]     store_data;
  logic                      reg_write_en;
  logic                      data_write_en;
  logic                      reg_select;
  logic [1:0]                mem_size;
  logic                      mem_unsigned;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic                      stall;
  logic                      dmem_req;
  logic                      dmem_we;
  logic [ADDR_WIDTH-1:0]     dmem_addr;
  logic [DATA_WIDTH-1:0]     dmem_wdata;
  logic [STRB_WIDTH-1:0]     dmem_wstrb;
  logic                      dmem_ack;
  logic [DATA_WIDTH-1:0]     dmem_rdata;
  logic                      wb_valid;
  logic                      wb_reg_write;
  logic [REG_ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0]     wb_data;
  logic [ADDR_WIDTH-1:0]     wb_pc;
  logic                      misaligned;

  modport master (
    output flush, ex_valid, pc, alu_out, store_data, reg_write_en, data_write_en,
           reg_select, mem_size, mem_unsigned, rd, dmem_ack, dmem_rdata,
    input  stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
           wb_valid, wb_reg_write, wb_rd, wb_data, wb_pc, misaligned
  );

  modport slave (
    input  flush, ex_valid, pc, alu_out, store_data, reg_write_en, data_write_en,
           reg_select, mem_size, mem_unsigned, rd, dmem_ack, dmem_rdata,
    output stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
           wb_valid, wb_reg_write, wb_rd, wb_data, wb_pc, misaligned
  );

endinterface

// File: rtl/mem_stage_load_align.sv
// Picks the addressed lane out of a read word and sign/zero extends it.
module mem_load_align import mem_stage_pkg::*; (
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_addr_lo,
  input  mem_size_e             i_size,
  input  logic                  i_unsigned,
  output logic [DATA_WIDTH-1:0] o_data_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select followed by extension.
  always_comb begin
    case (i_addr_lo)
      2'b00:   w_byte = i_rdata[7:0];
      2'b01:   w_byte = i_rdata[15:8];
      2'b10:   w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      MEM_BYTE: o_data_c = i_unsigned ? {{(DATA_WIDTH-8){1'b0}}, w_byte}
                                      : {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      MEM_HALF: o_data_c = i_unsigned ? {{(DATA_WIDTH-16){1'b0}}, w_half}
                                      : {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      default:  o_data_c = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: registers execute results, runs load/store bus accesses,
// and emits a one-cycle writeback bundle per retired instruction.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);
  import mem_stage_pkg::*;

  state_e                    r_state, w_state;
  logic                      r_req, w_req;
  logic                      r_we, w_we;
  logic [ADDR_WIDTH-1:0]     r_addr, w_addr;
  logic [DATA_WIDTH-1:0]     r_wdata, w_wdata;
  logic [STRB_WIDTH-1:0]     r_wstrb, w_wstrb;
  logic                      r_reg_write, w_reg_write;
  logic [REG_ADDR_WIDTH-1:0] r_rd, w_rd;
  logic [ADDR_WIDTH-1:0]     r_pc, w_pc;
  logic                      r_is_load, w_is_load;
  mem_size_e                 r_size, w_size;
  logic                      r_unsigned, w_unsigned;
  logic [1:0]                r_off, w_off;
  logic                      r_flushed, w_flushed;
  wb_t                       r_wb, w_wb;
  logic                      r_misaligned, w_misaligned;
  mem_size_e                 w_size_in;
  logic [DATA_WIDTH-1:0]     w_load_c;

  mem_load_align u_load_align (
    .i_rdata    (bus.dmem_rdata),
    .i_addr_lo  (r_off),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data_c   (w_load_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    w_state      = r_state;
    w_req        = r_req;
    w_we         = r_we;
    w_addr       = r_addr;
    w_wdata      = r_wdata;
    w_wstrb      = r_wstrb;
    w_reg_write  = r_reg_write;
    w_rd         = r_rd;
    w_pc         = r_pc;
    w_is_load    = r_is_load;
    w_size       = r_size;
    w_unsigned   = r_unsigned;
    w_off        = r_off;
    w_flushed    = r_flushed;
    w_wb         = '0;
    w_misaligned = 1'b0;
    w_size_in    = mem_size_e'(bus.mem_size);

    case (r_state)
      ST_IDLE: begin
        if (bus.ex_valid && !bus.flush) begin
          // Stores and writes to x0 never update the register file.
          w_reg_write = bus.reg_write_en && !bus.data_write_en && (bus.rd != '0);
          w_rd        = bus.rd;
          w_pc        = bus.pc;
          w_is_load   = bus.reg_select && !bus.data_write_en;
          w_size      = w_size_in;
          w_unsigned  = bus.mem_unsigned;
          w_off       = bus.alu_out[1:0];
          w_flushed   = 1'b0;
          if (!(bus.reg_select || bus.data_write_en)) begin
            w_wb.valid     = 1'b1;
            w_wb.reg_write = w_reg_write;
            w_wb.rd        = bus.rd;
            w_wb.data      = bus.alu_out;
            w_wb.pc        = bus.pc;
          end else if (is_misaligned(w_size_in, bus.alu_out[1:0])) begin
            w_wb.valid   = 1'b1;
            w_wb.rd      = bus.rd;
            w_wb.pc      = bus.pc;
            w_misaligned = 1'b1;
          end else begin
            w_state = ST_ACCESS;
            w_req   = 1'b1;
            w_we    = bus.data_write_en;
            w_addr  = {bus.alu_out[ADDR_WIDTH-1:2], 2'b00};
            w_wdata = store_wdata(w_size_in, bus.store_data);
            w_wstrb = store_strb(w_size_in, bus.alu_out[1:0]);
          end
        end
      end
      ST_ACCESS: begin
        // The request stays up until ack; a flush only kills the writeback.
        if (bus.flush) w_flushed = 1'b1;
        if (bus.dmem_ack) begin
          w_state   = ST_IDLE;
          w_req     = 1'b0;
          w_we      = 1'b0;
          w_addr    = '0;
          w_wdata   = '0;
          w_wstrb   = '0;
          w_flushed = 1'b0;
          if (!(r_flushed || bus.flush)) begin
            w_wb.valid     = 1'b1;
            w_wb.reg_write = r_reg_write;
            w_wb.rd        = r_rd;
            w_wb.data      = r_is_load ? w_load_c : '0;
            w_wb.pc        = r_pc;
          end
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_reg_write  <= 1'b0;
      r_rd         <= '0;
      r_pc         <= '0;
      r_is_load    <= 1'b0;
      r_size       <= MEM_BYTE;
      r_unsigned   <= 1'b0;
      r_off        <= 2'b00;
      r_flushed    <= 1'b0;
      r_wb         <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_req        <= w_req;
      r_we         <= w_we;
      r_addr       <= w_addr;
      r_wdata      <= w_wdata;
      r_wstrb      <= w_wstrb;
      r_reg_write  <= w_reg_write;
      r_rd         <= w_rd;
      r_pc         <= w_pc;
      r_is_load    <= w_is_load;
      r_size       <= w_size;
      r_unsigned   <= w_unsigned;
      r_off        <= w_off;
      r_flushed    <= w_flushed;
      r_wb         <= w_wb;
      r_misaligned <= w_misaligned;
    end
  end

  assign bus.stall        = (r_state == ST_ACCESS);
  assign bus.dmem_req     = r_req;
  assign bus.dmem_we      = r_we;
  assign bus.dmem_addr    = r_addr;
  assign bus.dmem_wdata   = r_wdata;
  assign bus.dmem_wstrb   = r_wstrb;
  assign bus.wb_valid     = r_wb.valid;
  assign bus.wb_reg_write = r_wb.reg_write;
  assign bus.wb_rd        = r_wb.rd;
  assign bus.wb_data      = r_wb.data;
  assign bus.wb_pc        = r_wb.pc;
  assign bus.misaligned   = r_misaligned;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU ops, loads, stores, misalignment, flush, reset.
module tb_mem_stage;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   stalls;

  mem_stage_if bus ();

  mem_stage u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one instruction for a single cycle; returns at the following negedge.
  task automatic issue(input logic [31:0] a_pc, input logic [31:0] alu, input logic [31:0] sd,
                       input logic rwe, input logic dwe, input logic rsel,
                       input logic [1:0] sz, input logic uns, input logic [4:0] rdi,
                       input logic fl);
    bus.ex_valid      = 1'b1;
    bus.pc            = a_pc;
    bus.alu_out       = alu;
    bus.store_data    = sd;
    bus.reg_write_en  = rwe;
    bus.data_write_en = dwe;
    bus.reg_select    = rsel;
    bus.mem_size      = sz;
    bus.mem_unsigned  = uns;
    bus.rd            = rdi;
    bus.flush         = fl;
    @(negedge clk);
    bus.ex_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  // Ack after 'delay' wait cycles; counts cycles seen with stall high.
  task automatic serve(input int delay, input logic [31:0] rdata, output int stall_cnt);
    stall_cnt = 0;
    for (int i = 0; i <= delay; i++) begin
      if (bus.stall === 1'b1) stall_cnt++;
      if (i == delay) begin
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = rdata;
      end
      @(negedge clk);
    end
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = '0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; stalls = 0;
    rst = 1'b0;
    bus.flush = 0; bus.ex_valid = 0; bus.pc = '0; bus.alu_out = '0; bus.store_data = '0;
    bus.reg_write_en = 0; bus.data_write_en = 0; bus.reg_select = 0; bus.mem_size = 2'b00;
    bus.mem_unsigned = 0; bus.rd = '0; bus.dmem_ack = 0; bus.dmem_rdata = '0;

    // Reset state
    #3;
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_req", 32'(bus.dmem_req), 32'd0);
    check("rst_wstrb", 32'(bus.dmem_wstrb), 32'd0);
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_misaligned", 32'(bus.misaligned), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // ALU op: latency 1, no stall
    issue(32'h40, 32'h1234, 32'h0, 1, 0, 0, 2'b10, 0, 5'd5, 0);
    check("alu_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("alu_wb_rd", 32'(bus.wb_rd), 32'd5);
    check("alu_wb_data", bus.wb_data, 32'h1234);
    check("alu_wb_regw", 32'(bus.wb_reg_write), 32'd1);
    check("alu_wb_pc", bus.wb_pc, 32'h40);
    check("alu_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    check("alu_wb_pulse", 32'(bus.wb_valid), 32'd0);

    // LB at 0x103, ack 3 cycles after request
    issue(32'h44, 32'h103, 32'h0, 1, 0, 1, 2'b00, 0, 5'd7, 0);
    check("lb_req", 32'(bus.dmem_req), 32'd1);
    check("lb_we", 32'(bus.dmem_we), 32'd0);
    check("lb_addr", bus.dmem_addr, 32'h100);
    serve(3, 32'h80FF_0000, stalls);
    check("lb_stall_cycles", 32'(stalls), 32'd4);
    check("lb_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("lb_wb_data", bus.wb_data, 32'hFFFF_FF80);
    check("lb_wb_rd", 32'(bus.wb_rd), 32'd7);
    check("lb_req_drop", 32'(bus.dmem_req), 32'd0);
    check("lb_stall_drop", 32'(bus.stall), 32'd0);
    @(negedge clk);

    // LBU same access, same-cycle ack
    issue(32'h48, 32'h103, 32'h0, 1, 0, 1, 2'b00, 1, 5'd7, 0);
    serve(0, 32'h80FF_0000, stalls);
    check("lbu_stall_cycles", 32'(stalls), 32'd1);
    check("lbu_wb_data", bus.wb_data, 32'h0000_0080);
    @(negedge clk);

    // LH at 0x102, signed upper half
    issue(32'h4C, 32'h102, 32'h0, 1, 0, 1, 2'b01, 0, 5'd8, 0);
    serve(1, 32'h8001_1234, stalls);
    check("lh_wb_data", bus.wb_data, 32'hFFFF_8001);
    @(negedge clk);

    // SH at 0x202
    issue(32'h50, 32'h202, 32'h0000_ABCD, 0, 1, 0, 2'b01, 0, 5'd3, 0);
    check("sh_we", 32'(bus.dmem_we), 32'd1);
    check("sh_wstrb", 32'(bus.dmem_wstrb), 32'hC);
    check("sh_wdata", bus.dmem_wdata, 32'hABCD_ABCD);
    check("sh_addr", bus.dmem_addr, 32'h200);
    serve(1, 32'h0, stalls);
    check("sh_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("sh_wb_regw", 32'(bus.wb_reg_write), 32'd0);
    @(negedge clk);

    // SB at 0x101
    issue(32'h54, 32'h101, 32'h1234_565A, 0, 1, 0, 2'b00, 0, 5'd3, 0);
    check("sb_wstrb", 32'(bus.dmem_wstrb), 32'h2);
    check("sb_wdata", bus.dmem_wdata, 32'h5A5A_5A5A);
    serve(0, 32'h0, stalls);
    @(negedge clk);

    // LW misaligned at 0x301
    issue(32'h58, 32'h301, 32'h0, 1, 0, 1, 2'b10, 0, 5'd4, 0);
    check("mis_req", 32'(bus.dmem_req), 32'd0);
    check("mis_flag", 32'(bus.misaligned), 32'd1);
    check("mis_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("mis_wb_regw", 32'(bus.wb_reg_write), 32'd0);
    check("mis_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    check("mis_flag_pulse", 32'(bus.misaligned), 32'd0);
    check("mis_wb_pulse", 32'(bus.wb_valid), 32'd0);
    check("mis_req_later", 32'(bus.dmem_req), 32'd0);

    // Load to x0
    issue(32'h5C, 32'h500, 32'h0, 1, 0, 1, 2'b10, 0, 5'd0, 0);
    serve(0, 32'hDEAD_BEEF, stalls);
    check("x0_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("x0_wb_regw", 32'(bus.wb_reg_write), 32'd0);
    check("x0_wb_data", bus.wb_data, 32'hDEAD_BEEF);
    @(negedge clk);

    // Flush in IDLE drops the op
    issue(32'h60, 32'h77, 32'h0, 1, 0, 0, 2'b10, 0, 5'd9, 1);
    check("fidle_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("fidle_stall", 32'(bus.stall), 32'd0);

    // Flush for one cycle mid-ACCESS
    issue(32'h64, 32'h504, 32'h0, 1, 0, 1, 2'b10, 0, 5'd6, 0);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("facc_req_held", 32'(bus.dmem_req), 32'd1);
    check("facc_addr_held", bus.dmem_addr, 32'h504);
    check("facc_stall", 32'(bus.stall), 32'd1);
    serve(1, 32'h1111_2222, stalls);
    check("facc_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("facc_req_drop", 32'(bus.dmem_req), 32'd0);
    check("facc_stall_drop", 32'(bus.stall), 32'd0);
    @(negedge clk);
    check("facc_wb_after", 32'(bus.wb_valid), 32'd0);

    // Asynchronous reset during ACCESS
    issue(32'h68, 32'h300, 32'h0, 1, 0, 1, 2'b10, 0, 5'd2, 0);
    check("arst_req_before", 32'(bus.dmem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_req", 32'(bus.dmem_req), 32'd0);
    check("arst_stall", 32'(bus.stall), 32'd0);
    check("arst_wb_valid", 32'(bus.wb_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // LW at 0x400 after reset release
    issue(32'h6C, 32'h400, 32'h0, 1, 0, 1, 2'b10, 0, 5'd9, 0);
    check("post_addr", bus.dmem_addr, 32'h400);
    serve(2, 32'h1122_3344, stalls);
    check("post_stall_cycles", 32'(stalls), 32'd3);
    check("post_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("post_wb_data", bus.wb_data, 32'h1122_3344);
    check("post_wb_rd", 32'(bus.wb_rd), 32'd9);
    check("post_wb_pc", bus.wb_pc, 32'h6C);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
